// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type and counter width for the data-memory responder
package dmem_pkg;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - word-wide storage with byte-lane writes and a registered read port
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_rd,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];

  // No reset: contents survive rst_i, and o_rdata is qualified by the top.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_rd) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - single-outstanding data-memory responder with programmable wait states
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  input  logic        d_rd_i,
  input  logic        d_wr_i,
  input  logic [3:0]  d_we_i,
  output logic [31:0] d_data_o,
  output logic        d_ready_o,
  output logic        d_err_o
);
  localparam int             AW      = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LP_WAIT = CNT_W'(WAIT_STATES);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_idx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_we;
  logic             r_rd, r_err, r_data_sel;

  logic             w_req, w_err, w_enter_resp, w_cur_rd, w_ram_rd, w_unused_lsb;
  logic [29:0]      w_word;
  logic [AW-1:0]    w_ram_raddr;
  logic [3:0]       w_ram_we;
  logic [31:0]      w_ram_q;

  assign w_req        = d_rd_i | d_wr_i;
  assign w_word       = d_addr_i[31:2] - BASE_ADDR[31:2];
  assign w_unused_lsb = ^d_addr_i[1:0];
  assign w_err        = (d_addr_i[31:2] < BASE_ADDR[31:2]) || (w_word >= 30'(DEPTH_WORDS))
                        || (d_rd_i && d_wr_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    unique case (r_state)
      IDLE: if (w_req) begin
        if (WAIT_STATES == 0) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: if (r_cnt == CNT_W'(1)) begin
        w_next       = RESP;
        w_enter_resp = 1'b1;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_we    <= '0;
      r_rd    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_cnt   <= LP_WAIT;
          r_idx   <= w_word[AW-1:0];
          r_wdata <= d_data_i;
          r_we    <= d_we_i;
          r_rd    <= d_rd_i;
          r_err   <= w_err;
        end
        WAIT:    r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Without wait states the read is launched straight from the request inputs.
  assign w_cur_rd    = (r_state == IDLE) ? d_rd_i : r_rd;
  assign w_ram_rd    = w_enter_resp && ((r_state == IDLE) ? (d_rd_i && !w_err) : (r_rd && !r_err));
  assign w_ram_raddr = (r_state == IDLE) ? w_word[AW-1:0] : r_idx;
  assign w_ram_we    = (r_state == RESP && !r_rd && !r_err) ? r_we : 4'b0000;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                       r_data_sel <= 1'b0;
    else if (w_enter_resp && w_cur_rd) r_data_sel <= w_ram_rd;
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i   (clk_i),
    .i_we    (w_ram_we),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_rd    (w_ram_rd),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_q)
  );

  assign d_ready_o = (r_state == RESP);
  assign d_err_o   = d_ready_o && r_err;
  assign d_data_o  = (d_err_o || !r_data_sel) ? 32'h0 : w_ram_q;
endmodule
